// File: rtl/mux_pipe_stage_if.sv
// Handshake bundle for mux_pipe_stage: upstream select/valid/ready,
// downstream data/valid/ready, flush and the sticky select-error flag.
interface mux_pipe_stage_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = 2
);
  logic [NUM_INPUTS*WIDTH-1:0] words;
  logic [SEL_WIDTH-1:0]        sel;
  logic                        up_valid;
  logic                        up_ready;
  logic [WIDTH-1:0]            dn_data;
  logic                        dn_valid;
  logic                        dn_ready;
  logic                        flush;
  logic                        sel_error;

  modport master (
    output words, sel, up_valid, dn_ready, flush,
    input  up_ready, dn_data, dn_valid, sel_error
  );

  modport slave (
    input  words, sel, up_valid, dn_ready, flush,
    output up_ready, dn_data, dn_valid, sel_error
  );
endinterface

// File: rtl/mux_pipe_stage.sv
// Registered N:1 multiplexer with valid/ready handshake and a one-entry skid register.
// Optional out-of-range select checking is enabled by defining MUX_SEL_CHECK_EN.
module mux_pipe_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input logic             clk,
  input logic             rst,
  mux_pipe_stage_if.slave bus
);

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] skid_data;
  logic             out_valid;
  logic             skid_valid;
  logic             ready_q;
  logic             accept;

  assign accept       = bus.up_valid & ready_q;
  assign bus.up_ready = ready_q;
  assign bus.dn_data  = out_data;
  assign bus.dn_valid = out_valid;

`ifdef MUX_SEL_CHECK_EN
  logic sel_bad;
  logic sel_error_q;

  assign sel_bad = 32'(bus.sel) >= NUM_INPUTS;

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (32'(bus.sel) == i) word = bus.words[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_error_q <= 1'b0;
    else if (accept && sel_bad) sel_error_q <= 1'b1;
  end

  assign bus.sel_error = sel_error_q;
`else
  // Out-of-range selects fall through to input 0.
  always_comb begin
    word = bus.words[WIDTH-1:0];
    for (int unsigned i = 1; i < NUM_INPUTS; i++) begin
      if (32'(bus.sel) == i) word = bus.words[i*WIDTH +: WIDTH];
    end
  end

  assign bus.sel_error = 1'b0;
`endif

  // ready_q mirrors ~skid_valid as a flop, held low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
    end else if (bus.flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (!out_valid || bus.dn_ready) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= accept;
        ready_q    <= !accept;
        if (accept) skid_data <= word;
      end else begin
        out_valid <= accept;
        ready_q   <= 1'b1;
        if (accept) out_data <= word;
      end
    end else if (accept) begin
      skid_data  <= word;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end

endmodule
